// File: rtl/weighted_seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : weighted_seq_divider_if
//  Purpose  : Operand/result handshake bundle for weighted_seq_divider.
//             Upstream side (master) drives the operands and out_ready.
//             The divider (slave) returns in_ready and the registered result.
//  Signals  : in_valid/in_ready    operand handshake
//             dividend [DW]        signed dividend
//             divisor  [DW]        unsigned divisor
//             weight   [WW]        base weight
//             out_valid/out_ready  result handshake
//             quot [QW], rem [DW], neg, result [WW], ovf, dbz
//  Revision : 1.0  initial release
// ============================================================================
interface weighted_seq_divider_if #(
   parameter int DW = 29,
   parameter int QW = 16,
   parameter int WW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic [WW-1:0] weight;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quot;
   logic [DW-1:0] rem;
   logic          neg;
   logic [WW-1:0] result;
   logic          ovf;
   logic          dbz;

   modport master (
      output in_valid, dividend, divisor, weight, out_ready,
      input  in_ready, out_valid, quot, rem, neg, result, ovf, dbz
   );

   modport slave (
      input  in_valid, dividend, divisor, weight, out_ready,
      output in_ready, out_valid, quot, rem, neg, result, ovf, dbz
   );
endinterface
`default_nettype wire

// File: rtl/weighted_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : weighted_seq_divider
//  Purpose  : Multi-cycle restoring divider for the delay-weight path.
//             Q = |dividend| * 2^FRAC / divisor, then result = weight +/- Q
//             (sign taken from the dividend), with clamp or wrap per SAT.
//             Flags remainder, divide-by-zero and overflow.
//  Ports    : clk  - clock, all state on rising edge
//             rst  - synchronous active-high reset
//             bus  - weighted_seq_divider_if.slave (operand/result handshake)
//  Timing   : accept at edge E, out_valid high after edge E+N+1, N=DW+FRAC.
//  Revision : 1.0  initial release
// ============================================================================
module weighted_seq_divider #(
   parameter int DW   = 29,
   parameter int FRAC = 0,
   parameter int QW   = 16,
   parameter int WW   = 16,
   parameter int SAT  = 1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   weighted_seq_divider_if.slave   bus
);
   localparam int N  = DW + FRAC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // Result arithmetic is signed and two bits wider than the widest operand
   localparam int RW = ((QW > WW) ? QW : WW) + 2;

   localparam logic [CW-1:0]        c_LAST = CW'(N - 1);
   localparam logic signed [RW-1:0] c_RMAX = {{(RW-WW){1'b0}}, {WW{1'b1}}};

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_FIN  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nx;
   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_accept;

   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_num;     // numerator bits shift out the top, quotient bits in at the bottom
   logic [DW-1:0] r_pr;      // partial remainder, always < divisor after each step
   logic [DW-1:0] r_div;
   logic [DW-1:0] r_mag;
   logic [WW-1:0] r_weight;
   logic          r_sign;
   logic          r_dbz_c;

   logic [QW-1:0] r_quot;
   logic [DW-1:0] r_rem;
   logic          r_neg;
   logic [WW-1:0] r_result;
   logic          r_ovf;
   logic          r_dbz;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         c_IDLE:  if (bus.in_valid)      w_state_nx = c_CALC;
         c_CALC:  if (r_cnt == c_LAST)   w_state_nx = c_FIN;
         c_FIN:                          w_state_nx = c_DONE;
         c_DONE:  if (bus.out_ready)     w_state_nx = c_IDLE;
         default:                        w_state_nx = c_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready  = (r_state == c_IDLE);
      w_out_valid = (r_state == c_DONE);
   end

   assign w_accept = w_in_ready & bus.in_valid;

   // ---------------------------------------------------------------- capture
   // Negating -2^(DW-1) in DW bits yields 2^(DW-1), which is the correct
   // unsigned magnitude.
   logic [DW-1:0] w_mag;
   logic [N-1:0]  w_num_init;

   assign w_mag = bus.dividend[DW-1] ? (DW'(0) - bus.dividend) : bus.dividend;

   always_comb begin
      w_num_init            = '0;
      w_num_init[N-1 -: DW] = w_mag;
   end

   // ---------------------------------------------------------------- step
   // The shifted partial remainder is DW+1 bits wide. If its top bit is set
   // it certainly exceeds the divisor, and the difference fits in DW bits,
   // so the subtraction can be done on the low DW bits alone.
   logic          w_top;
   logic [DW-1:0] w_low;
   logic          w_ge;
   logic [DW-1:0] w_pr_nx;

   assign w_top   = r_pr[DW-1];
   assign w_low   = {r_pr[DW-2:0], r_num[N-1]};
   assign w_ge    = w_top | (w_low >= r_div);
   assign w_pr_nx = w_ge ? (w_low - r_div) : w_low;

   // ---------------------------------------------------------------- finish
   logic [N-1:0]           w_q_full;
   logic                   w_q_ovf;
   logic [QW-1:0]          w_q_lo;
   logic [QW-1:0]          w_quot;
   logic [DW-1:0]          w_rem;
   logic signed [RW-1:0]   w_w_ext;
   logic signed [RW-1:0]   w_q_ext;
   logic signed [RW-1:0]   w_sum;
   logic                   w_lo;
   logic                   w_hi;
   logic [WW-1:0]          w_result;
   logic                   w_ovf;

   // Divide-by-zero reports an all-ones quotient regardless of the datapath
   assign w_q_full = r_dbz_c ? {N{1'b1}} : r_num;

   generate
      if (N > QW) begin : g_q_wide
         assign w_q_ovf = |w_q_full[N-1:QW];
         assign w_q_lo  = w_q_full[QW-1:0];
      end else begin : g_q_narrow
         assign w_q_ovf = 1'b0;
         assign w_q_lo  = QW'(w_q_full);
      end
   endgenerate

   assign w_quot  = ((SAT != 0) && w_q_ovf) ? {QW{1'b1}} : w_q_lo;
   assign w_rem   = r_dbz_c ? r_mag : r_pr;

   assign w_w_ext = {{(RW-WW){1'b0}}, r_weight};
   assign w_q_ext = {{(RW-QW){1'b0}}, w_quot};
   assign w_sum   = r_sign ? (w_w_ext - w_q_ext) : (w_w_ext + w_q_ext);
   assign w_lo    = w_sum[RW-1];
   assign w_hi    = !w_lo && (w_sum > c_RMAX);

   always_comb begin
      w_result = w_sum[WW-1:0];
      if (SAT != 0) begin
         if (w_lo)      w_result = '0;
         else if (w_hi) w_result = {WW{1'b1}};
      end
   end

   assign w_ovf = r_dbz_c | w_q_ovf | w_lo | w_hi;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_num    <= '0;
         r_pr     <= '0;
         r_div    <= '0;
         r_mag    <= '0;
         r_weight <= '0;
         r_sign   <= 1'b0;
         r_dbz_c  <= 1'b0;
         r_quot   <= '0;
         r_rem    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_num    <= w_num_init;
            r_pr     <= '0;
            r_div    <= bus.divisor;
            r_mag    <= w_mag;
            r_weight <= bus.weight;
            r_sign   <= bus.dividend[DW-1];
            r_dbz_c  <= (bus.divisor == '0);
         end
         if (r_state == c_CALC) begin
            r_pr  <= w_pr_nx;
            r_num <= {r_num[N-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
         end
         // Outputs change only here and hold until the next FIN
         if (r_state == c_FIN) begin
            r_quot   <= w_quot;
            r_rem    <= w_rem;
            r_neg    <= r_sign;
            r_result <= w_result;
            r_ovf    <= w_ovf;
            r_dbz    <= r_dbz_c;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.quot      = r_quot;
   assign bus.rem       = r_rem;
   assign bus.neg       = r_neg;
   assign bus.result    = r_result;
   assign bus.ovf       = r_ovf;
   assign bus.dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_weighted_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weighted_seq_divider
//  Purpose  : Self-checking bench. Three divider instances (default,
//             SAT=0, FRAC=4) share one operand stream; a reference model
//             pushes expected results into per-instance queues which a
//             monitor pops on each output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_weighted_seq_divider;
   localparam int DW = 29;
   localparam int QW = 16;
   localparam int WW = 16;

   typedef struct packed {
      logic [QW-1:0] quot;
      logic [DW-1:0] rem;
      logic          neg;
      logic [WW-1:0] result;
      logic          ovf;
      logic          dbz;
   } res_t;

   typedef struct packed {
      res_t        r;
      logic [31:0] acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic [WW-1:0] weight;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   weighted_seq_divider_if #(.DW(DW), .QW(QW), .WW(WW)) u_if_a ();
   weighted_seq_divider_if #(.DW(DW), .QW(QW), .WW(WW)) u_if_b ();
   weighted_seq_divider_if #(.DW(DW), .QW(QW), .WW(WW)) u_if_c ();

   weighted_seq_divider #(.DW(DW), .FRAC(0), .QW(QW), .WW(WW), .SAT(1))
      u_dut_a (.clk(clk), .rst(rst), .bus(u_if_a));
   weighted_seq_divider #(.DW(DW), .FRAC(0), .QW(QW), .WW(WW), .SAT(0))
      u_dut_b (.clk(clk), .rst(rst), .bus(u_if_b));
   weighted_seq_divider #(.DW(DW), .FRAC(4), .QW(QW), .WW(WW), .SAT(1))
      u_dut_c (.clk(clk), .rst(rst), .bus(u_if_c));

   assign u_if_a.in_valid = in_valid;  assign u_if_b.in_valid = in_valid;  assign u_if_c.in_valid = in_valid;
   assign u_if_a.dividend = dividend;  assign u_if_b.dividend = dividend;  assign u_if_c.dividend = dividend;
   assign u_if_a.divisor  = divisor;   assign u_if_b.divisor  = divisor;   assign u_if_c.divisor  = divisor;
   assign u_if_a.weight   = weight;    assign u_if_b.weight   = weight;    assign u_if_c.weight   = weight;
   assign u_if_a.out_ready = out_ready; assign u_if_b.out_ready = out_ready; assign u_if_c.out_ready = out_ready;

   logic [2:0] rdy;
   logic [2:0] vld;
   res_t       obs [3];

   assign rdy = {u_if_c.in_ready, u_if_b.in_ready, u_if_a.in_ready};
   assign vld = {u_if_c.out_valid, u_if_b.out_valid, u_if_a.out_valid};
   assign obs[0] = {u_if_a.quot, u_if_a.rem, u_if_a.neg, u_if_a.result, u_if_a.ovf, u_if_a.dbz};
   assign obs[1] = {u_if_b.quot, u_if_b.rem, u_if_b.neg, u_if_b.result, u_if_b.ovf, u_if_b.dbz};
   assign obs[2] = {u_if_c.quot, u_if_c.rem, u_if_c.neg, u_if_c.result, u_if_c.ovf, u_if_c.dbz};

   function automatic int frac_of(input int k); return (k == 2) ? 4 : 0; endfunction
   function automatic int sat_of(input int k);  return (k == 1) ? 0 : 1; endfunction
   function automatic int n_of(input int k);    return DW + frac_of(k);  endfunction

   // ---------------------------------------------------------------- model
   function automatic res_t model(input logic signed [DW-1:0] dvd, input logic [DW-1:0] dvs,
                                  input logic [WW-1:0] w, input int frac, input int sat);
      res_t   m;
      longint sd, mag, num, q, rm, quot, r, qmax, wmax;
      bit     dbz, qovf, rovf;
      dbz  = 1'b0;
      qmax = (longint'(1) << QW) - 1;
      wmax = (longint'(1) << WW) - 1;
      sd   = longint'(dvd);
      m.neg = (sd < 0);
      mag  = m.neg ? -sd : sd;
      num  = mag << frac;
      if (dvs == '0) begin
         dbz = 1'b1;
         q   = (longint'(1) << (DW + frac)) - 1;
         rm  = mag;
      end else begin
         q  = num / longint'(dvs);
         rm = num % longint'(dvs);
      end
      qovf = (q > qmax);
      quot = qovf ? ((sat != 0) ? qmax : (q & qmax)) : q;
      r    = m.neg ? (longint'(w) - quot) : (longint'(w) + quot);
      rovf = (r < 0) || (r > wmax);
      if (sat != 0) r = (r < 0) ? 0 : ((r > wmax) ? wmax : r);
      else          r = r & wmax;
      m.quot   = quot[QW-1:0];
      m.rem    = rm[DW-1:0];
      m.result = r[WW-1:0];
      m.dbz    = dbz;
      m.ovf    = dbz | qovf | rovf;
      return m;
   endfunction

   // ---------------------------------------------------------------- scoreboard
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t sb2[$];

   function automatic int sb_size(input int k);
      case (k)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic exp_t sb_front(input int k);
      case (k)
         0:       return sb0[0];
         1:       return sb1[0];
         default: return sb2[0];
      endcase
   endfunction

   function automatic exp_t sb_pop(input int k);
      case (k)
         0:       return sb0.pop_front();
         1:       return sb1.pop_front();
         default: return sb2.pop_front();
      endcase
   endfunction

   task automatic sb_push(input int k, input exp_t e);
      case (k)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   logic [2:0] prev_vld = 3'b000;

   always @(negedge clk) begin : p_mon
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (rst === 1'b0 && vld[k] === 1'b1) begin
            if (prev_vld[k] == 1'b0) begin
               checks++;
               if (sb_size(k) == 0) begin
                  errors++;
                  $display("FAIL unexpected_out dut%0d: out_valid=1 want 0 (nothing pending)", k);
               end else begin
                  e = sb_front(k);
                  if (cyc - int'(e.acc) != n_of(k) + 1) begin
                     errors++;
                     $display("FAIL latency dut%0d: got %0d edges want %0d", k, cyc - int'(e.acc), n_of(k) + 1);
                  end
               end
            end
            if (out_ready === 1'b1 && sb_size(k) != 0) begin
               e = sb_pop(k);
               checks++;
               if (obs[k] !== e.r) begin
                  errors++;
                  $display("FAIL result dut%0d: got quot=%0d rem=%0d neg=%0d result=%0d ovf=%0d dbz=%0d want quot=%0d rem=%0d neg=%0d result=%0d ovf=%0d dbz=%0d",
                           k, obs[k].quot, obs[k].rem, obs[k].neg, obs[k].result, obs[k].ovf, obs[k].dbz,
                           e.r.quot, e.r.rem, e.r.neg, e.r.result, e.r.ovf, e.r.dbz);
               end
            end
         end
         prev_vld[k] = vld[k];
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs, input logic [WW-1:0] w);
      int   t;
      exp_t e;
      t = 0;
      while (rdy !== 3'b111 && t < 200) begin
         tick();
         t++;
      end
      if (rdy !== 3'b111) begin
         checks++;
         errors++;
         $display("FAIL send_ready: in_ready=%b want 111", rdy);
      end else begin
         in_valid = 1'b1;
         dividend = dvd;
         divisor  = dvs;
         weight   = w;
         tick();
         in_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            e.r   = model(dvd, dvs, w, frac_of(k), sat_of(k));
            e.acc = 32'(cyc);
            sb_push(k, e);
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && t < 500) begin
         tick();
         t++;
      end
      if ((sb_size(0) + sb_size(1) + sb_size(2)) != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending=%0d want 0", sb_size(0) + sb_size(1) + sb_size(2));
      end
   endtask

   task automatic check_idle_zero(input string name);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy[k] !== 1'b1 || vld[k] !== 1'b0 || obs[k] !== '0) begin
            errors++;
            $display("FAIL %s dut%0d: in_ready=%b out_valid=%b outs=%h want 1 0 0", name, k, rdy[k], vld[k], obs[k]);
         end
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      check_idle_zero("reset");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      send(DW'(1000), DW'(7), WW'(100));
      send(DW'(-1000), DW'(7), WW'(100));
      send(DW'(5), DW'(0), WW'(9));
      send(DW'(-(1 << 28)), DW'(8192), WW'(40000));
      send(DW'(268435455), DW'(1), WW'(500));
      send(DW'(10), DW'(4), WW'(0));
      send(DW'(-1), DW'(3), WW'(0));
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) send(DW'($urandom()), DW'($urandom_range(1, 40000)), WW'($urandom()));
         else            send(DW'($urandom()), DW'($urandom()), WW'($urandom()));
      end
      drain();
   endtask

   task automatic test_stall();
      res_t m;
      int   t;
      m = model(DW'(12345), DW'(3), WW'(777), 0, 1);
      out_ready = 1'b0;
      send(DW'(12345), DW'(3), WW'(777));
      t = 0;
      while (vld[0] !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      checks++;
      if (vld[0] !== 1'b1) begin
         errors++;
         $display("FAIL stall_valid: out_valid=%b want 1", vld[0]);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = DW'(99);
         divisor  = DW'(1);
         weight   = '0;
         tick();
         checks++;
         if (vld[0] !== 1'b1 || rdy[0] !== 1'b0 || obs[0] !== m) begin
            errors++;
            $display("FAIL stall_hold: out_valid=%b in_ready=%b outs=%h want 1 0 %h", vld[0], rdy[0], obs[0], m);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (rdy[0] !== 1'b1 || vld[0] !== 1'b0 || obs[0] !== m) begin
         errors++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b outs=%h want 1 0 %h", rdy[0], vld[0], obs[0], m);
      end
      drain();
   endtask

   task automatic test_abort();
      send(DW'(1000), DW'(7), WW'(100));
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_idle_zero("abort");
      rst = 1'b0;
      sb0.delete();
      sb1.delete();
      sb2.delete();
      send(DW'(1000), DW'(7), WW'(100));
      drain();
   endtask

   task automatic test_back_to_back();
      send(DW'(77777), DW'(13), WW'(65000));
      send(DW'(-77777), DW'(13), WW'(2000));
      send(DW'(1 << 20), DW'(16), WW'(1));
      drain();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      weight    = '0;
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
